uart_rx_deser: RTL

UART receiver that deserialises the host serial line into bytes for the processor system's program/data loader, directly upstream of it. Bit period is runtime-programmable in clock cycles from the top-level `clk_per_bit` bus. The block synchronises the asynchronous `uart_rx` pin, detects start bits, samples each bit at mid-period, and presents bytes on a valid/ready handshake. Framing errors and overruns are flagged.

---
 rtl/uart_rx_deser.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/uart_rx_deser.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling with a runtime bit
// period, valid/ready byte output, one-cycle framing-error pulse, sticky overrun.
module uart_rx_deser #(
  parameter int CLK_BITS = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CLK_BITS-1:0] clk_per_bit,
  input  logic                uart_rx,
  output logic [7:0]          rx_data,
  output logic                rx_valid,
  input  logic                rx_ready,
  output logic                busy,
  output logic                frame_err,
  output logic                overrun
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // Bit periods below 4 cycles leave no room for a mid-bit sample point.
  function automatic logic [CLK_BITS-1:0] clamp_period(input logic [CLK_BITS-1:0] cpb);
    if (cpb < CLK_BITS'(4)) begin
      return CLK_BITS'(4);
    end
    return cpb;
  endfunction

  state_t              state_q, state_d;
  logic                sync1_q, sync1_d;
  logic                sync2_q, sync2_d;
  logic                prev_q, prev_d;
  logic [CLK_BITS-1:0] n_q, n_d;
  logic [CLK_BITS-1:0] cnt_q, cnt_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic [7:0]          shift_q, shift_d;
  logic [7:0]          rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                frame_err_q, frame_err_d;
  logic                overrun_q, overrun_d;

  logic                rxs;
  logic                fall;
  logic                tick;
  logic [CLK_BITS-1:0] n_new;

  assign rxs   = sync2_q;
  assign fall  = ~sync2_q & prev_q;
  assign tick  = (cnt_q == '0);
  assign n_new = clamp_period(clk_per_bit);

  always_comb begin
    sync1_d     = uart_rx;
    sync2_d     = sync1_q;
    prev_d      = sync2_q;
    state_d     = state_q;
    n_d         = n_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = overrun_q;

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    if (state_q != S_IDLE) begin
      cnt_d = tick ? (n_q - CLK_BITS'(1)) : (cnt_q - CLK_BITS'(1));
    end

    case (state_q)
      S_IDLE: begin
        // Half-period preload puts every later tick in the middle of a bit.
        if (fall) begin
          n_d     = n_new;
          cnt_d   = (n_new >> 1) - CLK_BITS'(1);
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          if (!rxs) begin
            state_d   = S_DATA;
            bit_idx_d = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d   = {rxs, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          state_d = S_IDLE;
          if (!rxs) begin
            frame_err_d = 1'b1;
          end else if (!rx_valid_q || rx_ready) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      state_q     <= S_IDLE;
      n_q         <= '0;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      state_q     <= state_d;
      n_q         <= n_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != S_IDLE);

endmodule
